// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state codes and helper types for the RAM/IO bus controller.
// Line geometry, IO decode, requester source tags and the arbiter grant encoding live here.
package mem_ctrl_pkg;

  localparam int CACHE_BLK_WIDTH = 128;
  localparam int LINE_BYTES      = CACHE_BLK_WIDTH / 8;
  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 8;
  localparam int LINE_A_WIDTH    = ADDR_WIDTH - 4;

  // Any address with addr[17:16] == IO_SEL is IO space.
  localparam logic [ADDR_WIDTH-1:0] IO_BASE = 32'h0003_0000;
  localparam logic [1:0]            IO_SEL  = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_LINE = 3'd1;
  localparam logic [2:0] ST_WR_LINE = 3'd2;
  localparam logic [2:0] ST_IO_RD   = 3'd3;
  localparam logic [2:0] ST_IO_WR   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [1:0] {
    SRC_IC = 2'd0,
    SRC_DC = 2'd1,
    SRC_IO = 2'd2
  } src_t;

  typedef enum logic [2:0] {
    GNT_NONE    = 3'd0,
    GNT_DC_WB   = 3'd1,
    GNT_IO      = 3'd2,
    GNT_DC_FILL = 3'd3,
    GNT_IC_FILL = 3'd4
  } grant_t;

  // Number of bus bytes for an IO access size code (01 byte, 10 half, 11 word).
  function automatic logic [2:0] io_bytes(input logic [1:0] io_type);
    case (io_type)
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Fixed-priority request selector for the memory bus: write-back > IO > dCache fill > iCache fill.
// Purely combinational; the caller decides when the grant is consumed.
module mem_arb
  import mem_ctrl_pkg::*;
(
  input  logic   dc_wb_req,
  input  logic   io_req,
  input  logic   dc_fill_req,
  input  logic   ic_req,
  output grant_t grant
);

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    grant = GNT_NONE;
    if (dc_wb_req)        grant = GNT_DC_WB;
    else if (io_req)      grant = GNT_IO;
    else if (dc_fill_req) grant = GNT_DC_FILL;
    else if (ic_req)      grant = GNT_IC_FILL;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sole owner of the byte-wide RAM/IO bus: serialises cache line fills, dCache write-backs
// and uncached IO loads/stores into one-byte bus beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       roll_back,
  input  logic [DATA_WIDTH-1:0]      mem_din,
  output logic [DATA_WIDTH-1:0]      mem_dout,
  output logic [ADDR_WIDTH-1:0]      mem_a,
  output logic                       mem_wr,
  input  logic                       io_buffer_full,
  input  logic                       ic_miss,
  input  logic [LINE_A_WIDTH-1:0]    ic_miss_a,
  input  logic                       dc_miss,
  input  logic [LINE_A_WIDTH-1:0]    dc_miss_a,
  input  logic                       dc_mem_rw,
  input  logic [CACHE_BLK_WIDTH-1:0] dc_wb_d,
  output logic [LINE_A_WIDTH-1:0]    fill_a,
  output logic [CACHE_BLK_WIDTH-1:0] fill_d,
  output logic                       ic_fill_en,
  output logic                       dc_fill_en,
  output logic                       dc_w_done,
  input  logic                       io_req,
  input  logic                       io_rw,
  input  logic [1:0]                 io_type,
  input  logic [31:0]                io_a,
  input  logic [31:0]                io_d,
  output logic                       io_dout_en,
  output logic [31:0]                io_dout,
  output logic                       io_w_done
);

  logic [2:0]                 state;
  logic [4:0]                 cnt;
  src_t                       src;
  logic                       wr_op;
  logic [CACHE_BLK_WIDTH-1:0] wb_d;
  logic [31:0]                io_a_q;
  logic [31:0]                io_d_q;
  logic [2:0]                 io_n;
  grant_t                     grant;
  logic [3:0]                 beat;
  logic [3:0]                 prev;
  logic                       done;

  mem_arb u_arb (
    .dc_wb_req   (dc_miss & ~dc_mem_rw),
    .io_req      (io_req & (io_rw | ~roll_back)),
    .dc_fill_req (dc_miss & dc_mem_rw),
    .ic_req      (ic_miss),
    .grant       (grant)
  );

  assign prev = cnt[3:0] - 4'd1;

  // While frozen in a read, the bus re-reads the byte that is still owed so that mem_din
  // holds the right byte on the first cycle after rdy_in returns.
  assign beat = (!rdy_in && cnt != 5'd0) ? prev : cnt[3:0];

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state)
      ST_RD_LINE: if (!rdy_in || cnt < 5'd16) mem_a = {fill_a, beat};
      ST_IO_RD:   if (!rdy_in || cnt < {2'b00, io_n}) mem_a = io_a_q + {28'd0, beat};
      ST_WR_LINE: begin
        mem_a    = {fill_a, cnt[3:0]};
        mem_dout = wb_d[{cnt[3:0], 3'b000} +: 8];
        mem_wr   = rdy_in;
      end
      ST_IO_WR: begin
        mem_a    = io_a_q + {27'd0, cnt};
        mem_dout = io_d_q[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in & ~io_buffer_full;
      end
      default: ;
    endcase
  end

  // Completion pulses are decoded from DONE so a frozen DONE cycle cannot stretch them.
  assign done       = (state == ST_DONE) & rdy_in;
  assign ic_fill_en = done & (src == SRC_IC);
  assign dc_fill_en = done & (src == SRC_DC) & ~wr_op;
  assign dc_w_done  = done & (src == SRC_DC) &  wr_op;
  assign io_dout_en = done & (src == SRC_IO) & ~wr_op;
  assign io_w_done  = done & (src == SRC_IO) &  wr_op;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      src     <= SRC_IC;
      wr_op   <= 1'b0;
      fill_a  <= '0;
      fill_d  <= '0;
      wb_d    <= '0;
      io_a_q  <= '0;
      io_d_q  <= '0;
      io_n    <= 3'd1;
      io_dout <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          case (grant)
            GNT_DC_WB: begin
              state  <= ST_WR_LINE;
              src    <= SRC_DC;
              wr_op  <= 1'b1;
              fill_a <= dc_miss_a;
              wb_d   <= dc_wb_d;
            end
            GNT_IO: begin
              state   <= io_rw ? ST_IO_WR : ST_IO_RD;
              src     <= SRC_IO;
              wr_op   <= io_rw;
              io_a_q  <= io_a;
              io_d_q  <= io_d;
              io_n    <= io_bytes(io_type);
              io_dout <= '0;
            end
            GNT_DC_FILL: begin
              state  <= ST_RD_LINE;
              src    <= SRC_DC;
              wr_op  <= 1'b0;
              fill_a <= dc_miss_a;
            end
            GNT_IC_FILL: begin
              state  <= ST_RD_LINE;
              src    <= SRC_IC;
              wr_op  <= 1'b0;
              fill_a <= ic_miss_a;
            end
            default: ;
          endcase
        end
        ST_RD_LINE: begin
          if (cnt != 5'd0) fill_d[{prev, 3'b000} +: 8] <= mem_din;
          if (cnt == 5'd16) state <= ST_DONE;
          else              cnt   <= cnt + 5'd1;
        end
        ST_WR_LINE: begin
          if (cnt == 5'd15) state <= ST_DONE;
          else              cnt   <= cnt + 5'd1;
        end
        ST_IO_RD: begin
          if (roll_back) begin
            state <= ST_IDLE;
          end else begin
            if (cnt != 5'd0) io_dout[{prev[1:0], 3'b000} +: 8] <= mem_din;
            if (cnt == {2'b00, io_n}) state <= ST_DONE;
            else                      cnt   <= cnt + 5'd1;
          end
        end
        ST_IO_WR: begin
          if (!io_buffer_full) begin
            if (cnt == {2'b00, io_n} - 5'd1) state <= ST_DONE;
            else                             cnt   <= cnt + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
